// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-requester data-memory port arbiter.
// Optional write protection of low addresses is enabled with MEM_ARB_WR_PROTECT_EN.
package mem_arb_pkg;

    localparam int DEF_DATA_W = 16;
    localparam int DEF_ADDR_W = 4;

    localparam logic REQ_CPU = 1'b0;
    localparam logic REQ_DBG = 1'b1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } arb_state_t;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Requester and memory-side signal bundle for mem_port_arbiter.
// The slave modport is the arbiter view; master is the requester/memory environment view.
interface mem_port_arbiter_if
    import mem_arb_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W
) ();

    logic              req0;
    logic              we0;
    logic [ADDR_W-1:0] addr0;
    logic [DATA_W-1:0] wdata0;
    logic              ack0;
    logic [DATA_W-1:0] rdata0;

    logic              req1;
    logic              we1;
    logic [ADDR_W-1:0] addr1;
    logic [DATA_W-1:0] wdata1;
    logic              ack1;
    logic [DATA_W-1:0] rdata1;
    logic              err1;

    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    modport slave (
        input  req0, we0, addr0, wdata0,
        input  req1, we1, addr1, wdata1,
        input  mem_rdata,
        output ack0, rdata0, ack1, rdata1, err1,
        output mem_en, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output req0, we0, addr0, wdata0,
        output req1, we1, addr1, wdata1,
        output mem_rdata,
        input  ack0, rdata0, ack1, rdata1, err1,
        input  mem_en, mem_we, mem_addr, mem_wdata
    );

endinterface

// File: rtl/rr_pick2.sv
// Combinational two-way round-robin pick: on a tie the requester that did not
// win last time is chosen.
module rr_pick2
    import mem_arb_pkg::*;
(
    input  logic req0,
    input  logic req1,
    input  logic last_grant,
    output logic grant_valid,
    output logic grant_idx
);

    always_comb begin
        grant_valid = req0 | req1;
        if (req0 && req1) begin
            grant_idx = (last_grant == REQ_CPU) ? REQ_DBG : REQ_CPU;
        end else begin
            grant_idx = req1 ? REQ_DBG : REQ_CPU;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares the single-port data memory between the CPU path and the debug loader
// via an IDLE/ACCESS/RESP sequence; MEM_ARB_WR_PROTECT_EN blocks debug writes below PROT_LIMIT.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int          DATA_W     = DEF_DATA_W,
    parameter int          ADDR_W     = DEF_ADDR_W,
    parameter int unsigned PROT_LIMIT = 4
) (
    input  logic                Clock,
    input  logic                Resetn,
    mem_port_arbiter_if.slave   bus
);

    localparam logic [ADDR_W:0] PROT_LIM_W = (ADDR_W+1)'(PROT_LIMIT);

    arb_state_t        state;
    logic              last_grant;
    logic              winner;
    logic              is_wr;
    logic              blocked;
    logic              grant_valid;
    logic              grant_idx;
    logic              prot;
    logic              sel_we;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;
    logic [DATA_W-1:0] resp_data;

    rr_pick2 u_pick (
        .req0        (bus.req0),
        .req1        (bus.req1),
        .last_grant  (last_grant),
        .grant_valid (grant_valid),
        .grant_idx   (grant_idx)
    );

    assign sel_we    = (grant_idx == REQ_DBG) ? bus.we1    : bus.we0;
    assign sel_addr  = (grant_idx == REQ_DBG) ? bus.addr1  : bus.addr0;
    assign sel_wdata = (grant_idx == REQ_DBG) ? bus.wdata1 : bus.wdata0;

`ifdef MEM_ARB_WR_PROTECT_EN
    assign prot = (grant_idx == REQ_DBG) && bus.we1 && ({1'b0, bus.addr1} < PROT_LIM_W);
`else
    logic unused_prot;
    assign prot        = 1'b0;
    assign unused_prot = ^PROT_LIM_W;
`endif

    // Writes answer with zero data so a stale read word never leaks to the requester.
    assign resp_data = is_wr ? '0 : bus.mem_rdata;

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            state         <= IDLE;
            last_grant    <= REQ_DBG;
            winner        <= REQ_CPU;
            is_wr         <= 1'b0;
            blocked       <= 1'b0;
            bus.mem_en    <= 1'b0;
            bus.mem_we    <= 1'b0;
            bus.mem_addr  <= '0;
            bus.mem_wdata <= '0;
            bus.ack0      <= 1'b0;
            bus.ack1      <= 1'b0;
            bus.err1      <= 1'b0;
            bus.rdata0    <= '0;
            bus.rdata1    <= '0;
        end else begin
            bus.ack0 <= 1'b0;
            bus.ack1 <= 1'b0;
            bus.err1 <= 1'b0;
            case (state)
                IDLE: begin
                    if (grant_valid) begin
                        winner        <= grant_idx;
                        last_grant    <= grant_idx;
                        is_wr         <= sel_we;
                        blocked       <= prot;
                        bus.mem_en    <= ~prot;
                        bus.mem_we    <= sel_we & ~prot;
                        bus.mem_addr  <= sel_addr;
                        bus.mem_wdata <= sel_wdata;
                        state         <= ACCESS;
                    end
                end
                ACCESS: begin
                    bus.mem_en <= 1'b0;
                    bus.mem_we <= 1'b0;
                    state      <= RESP;
                end
                RESP: begin
                    if (winner == REQ_DBG) begin
                        bus.ack1   <= 1'b1;
                        bus.rdata1 <= resp_data;
                        bus.err1   <= blocked;
                    end else begin
                        bus.ack0   <= 1'b1;
                        bus.rdata0 <= resp_data;
                    end
                    state <= IDLE;
                end
                default: begin
                    bus.mem_en <= 1'b0;
                    bus.mem_we <= 1'b0;
                    state      <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a behavioural registered memory and an
// ack scoreboard; protection checks follow MEM_ARB_WR_PROTECT_EN when defined.
module tb_mem_port_arbiter;

    logic Clock;
    logic Resetn;

    mem_port_arbiter_if #(.DATA_W(16), .ADDR_W(4)) bus ();

    mem_port_arbiter #(.DATA_W(16), .ADDR_W(4), .PROT_LIMIT(4)) dut (
        .Clock  (Clock),
        .Resetn (Resetn),
        .bus    (bus)
    );

    typedef struct {
        logic        idx;
        logic [15:0] rdata;
        logic        err;
    } exp_t;

    exp_t        sb[$];
    logic [15:0] mem[16];
    logic [15:0] shadow[16];
    int          total = 0;
    int          bad   = 0;

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    // Memory array: registered read-first, samples only while mem_en is high.
    always @(posedge Clock) begin
        if (bus.mem_en) begin
            if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;
            bus.mem_rdata <= mem[bus.mem_addr];
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard: every ack pulse consumes exactly one expected response.
    always @(negedge Clock) begin
        if (Resetn && (bus.ack0 || bus.ack1)) begin
            exp_t e;
            chk("ack_onehot", {31'd0, bus.ack0 & bus.ack1}, 32'd0);
            chk("sb_nonempty", {31'd0, sb.size() != 0}, 32'd1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                chk("ack_idx", {31'd0, bus.ack1}, {31'd0, e.idx});
                chk("rdata", {16'd0, bus.ack1 ? bus.rdata1 : bus.rdata0}, {16'd0, e.rdata});
                chk("err1", {31'd0, bus.err1}, {31'd0, e.err});
            end
        end
    end

    task automatic set_req(input logic idx, input logic r, input logic w,
                           input logic [3:0] a, input logic [15:0] d);
        if (idx) begin
            bus.req1 = r; bus.we1 = w; bus.addr1 = a; bus.wdata1 = d;
        end else begin
            bus.req0 = r; bus.we0 = w; bus.addr0 = a; bus.wdata0 = d;
        end
    endtask

    task automatic push_exp(input logic idx, input logic w, input logic [3:0] a,
                            input logic [15:0] d, output logic blk);
        exp_t e;
        blk = 1'b0;
`ifdef MEM_ARB_WR_PROTECT_EN
        blk = idx && w && (a < 4'd4);
`endif
        e.idx   = idx;
        e.rdata = w ? 16'h0000 : shadow[a];
        e.err   = blk;
        sb.push_back(e);
        if (w && !blk) shadow[a] = d;
    endtask

    task automatic do_single(input logic idx, input logic w, input logic [3:0] a,
                             input logic [15:0] d);
        logic blk;
        push_exp(idx, w, a, d, blk);
        @(posedge Clock); #1;
        set_req(idx, 1'b1, w, a, d);
        @(posedge Clock); #1;
        chk("acc_mem_en", {31'd0, bus.mem_en}, {31'd0, ~blk});
        chk("acc_mem_we", {31'd0, bus.mem_we}, {31'd0, w & ~blk});
        chk("acc_mem_addr", {28'd0, bus.mem_addr}, {28'd0, a});
        if (w) chk("acc_mem_wdata", {16'd0, bus.mem_wdata}, {16'd0, d});
        @(posedge Clock); #1;
        chk("resp_mem_en", {31'd0, bus.mem_en}, 32'd0);
        @(posedge Clock); #1;
        set_req(idx, 1'b0, 1'b0, 4'd0, 16'd0);
        chk("ack_hi", {31'd0, idx ? bus.ack1 : bus.ack0}, 32'd1);
        chk("ack_other_lo", {31'd0, idx ? bus.ack0 : bus.ack1}, 32'd0);
        @(posedge Clock); #1;
        chk("ack_pulse", {31'd0, idx ? bus.ack1 : bus.ack0}, 32'd0);
    endtask

    task automatic reset_pulse();
        @(posedge Clock); #1;
        Resetn = 1'b0;
        repeat (2) @(posedge Clock);
        #1 Resetn = 1'b1;
    endtask

    initial begin
        for (int i = 0; i < 16; i++) begin
            mem[i]    <= 16'(i + 1);
            shadow[i]  = 16'(i + 1);
        end
        bus.mem_rdata <= 16'h0000;
        Resetn = 1'b0;
        set_req(1'b0, 1'b0, 1'b0, 4'd0, 16'd0);
        set_req(1'b1, 1'b0, 1'b0, 4'd0, 16'd0);
        repeat (3) @(posedge Clock);
        #1;
        chk("rst_mem_en", {31'd0, bus.mem_en}, 32'd0);
        chk("rst_mem_we", {31'd0, bus.mem_we}, 32'd0);
        chk("rst_ack", {30'd0, bus.ack1, bus.ack0}, 32'd0);
        chk("rst_err1", {31'd0, bus.err1}, 32'd0);
        chk("rst_rdata", {bus.rdata1, bus.rdata0}, 32'd0);
        chk("rst_mem_addr", {12'd0, bus.mem_addr, bus.mem_wdata}, 32'd0);
        Resetn = 1'b1;

        // Reset lands in the ACCESS cycle of a write to addr 7.
        @(posedge Clock); #1;
        set_req(1'b0, 1'b1, 1'b1, 4'd7, 16'h7777);
        @(posedge Clock); #1;
        chk("mid_mem_we_up", {31'd0, bus.mem_we}, 32'd1);
        #2 Resetn = 1'b0;
        #1;
        chk("mid_mem_we_drop", {31'd0, bus.mem_we}, 32'd0);
        chk("mid_mem_en_drop", {31'd0, bus.mem_en}, 32'd0);
        set_req(1'b0, 1'b0, 1'b0, 4'd0, 16'd0);
        for (int k = 0; k < 3; k++) begin
            @(posedge Clock); #1;
            chk("mid_no_ack", {30'd0, bus.ack1, bus.ack0}, 32'd0);
        end
        Resetn = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(posedge Clock); #1;
            chk("post_rst_no_ack", {30'd0, bus.ack1, bus.ack0}, 32'd0);
        end
        chk("mem7_kept", {16'd0, mem[7]}, 32'h0008);

        do_single(1'b0, 1'b0, 4'd3, 16'd0);
        do_single(1'b0, 1'b0, 4'd7, 16'd0);
        do_single(1'b1, 1'b1, 4'd9, 16'hBEEF);
        do_single(1'b0, 1'b0, 4'd9, 16'd0);
        do_single(1'b0, 1'b1, 4'd15, 16'hA5A5);
        do_single(1'b1, 1'b0, 4'd15, 16'd0);
        do_single(1'b1, 1'b0, 4'd0, 16'd0);

        // Both requesters held from reset: grants alternate starting with requester 0.
        reset_pulse();
        begin
            logic blk;
            push_exp(1'b0, 1'b0, 4'd5, 16'd0, blk);
            push_exp(1'b1, 1'b0, 4'd6, 16'd0, blk);
            push_exp(1'b0, 1'b0, 4'd5, 16'd0, blk);
            push_exp(1'b1, 1'b0, 4'd6, 16'd0, blk);
        end
        @(posedge Clock); #1;
        set_req(1'b0, 1'b1, 1'b0, 4'd5, 16'd0);
        set_req(1'b1, 1'b1, 1'b0, 4'd6, 16'd0);
        for (int k = 0; k < 4; k++) begin
            @(posedge Clock); #1;
            chk("cont_mem_en", {31'd0, bus.mem_en}, 32'd1);
            chk("cont_order", {28'd0, bus.mem_addr}, (k % 2 == 0) ? 32'd5 : 32'd6);
            repeat (2) @(posedge Clock);
        end
        #1;
        set_req(1'b0, 1'b0, 1'b0, 4'd0, 16'd0);
        set_req(1'b1, 1'b0, 1'b0, 4'd0, 16'd0);
        repeat (3) @(posedge Clock);
        #1 chk("cont_idle", {31'd0, bus.mem_en}, 32'd0);

        // req0 held past its ack starts a second access; req1 raised meanwhile follows.
        begin
            logic blk;
            push_exp(1'b0, 1'b0, 4'd1, 16'd0, blk);
            push_exp(1'b0, 1'b0, 4'd1, 16'd0, blk);
            push_exp(1'b1, 1'b0, 4'd2, 16'd0, blk);
        end
        @(posedge Clock); #1;
        set_req(1'b0, 1'b1, 1'b0, 4'd1, 16'd0);
        @(posedge Clock);
        repeat (3) @(posedge Clock);
        #1;
        chk("held_second_en", {31'd0, bus.mem_en}, 32'd1);
        chk("held_second_addr", {28'd0, bus.mem_addr}, 32'd1);
        set_req(1'b1, 1'b1, 1'b0, 4'd2, 16'd0);
        repeat (2) @(posedge Clock);
        #1 set_req(1'b0, 1'b0, 1'b0, 4'd0, 16'd0);
        @(posedge Clock); #1;
        chk("held_next_en", {31'd0, bus.mem_en}, 32'd1);
        chk("held_next_addr", {28'd0, bus.mem_addr}, 32'd2);
        repeat (2) @(posedge Clock);
        #1 set_req(1'b1, 1'b0, 1'b0, 4'd0, 16'd0);
        repeat (4) @(posedge Clock);
        #1;
        chk("rdata1_hold", {16'd0, bus.rdata1}, {16'd0, shadow[2]});
        chk("rdata0_hold", {16'd0, bus.rdata0}, {16'd0, shadow[1]});

        // Debug write into the low region, read back, then a CPU write to the same word.
        do_single(1'b1, 1'b1, 4'd2, 16'h1234);
        do_single(1'b1, 1'b0, 4'd2, 16'd0);
        do_single(1'b0, 1'b1, 4'd2, 16'h5555);
        do_single(1'b1, 1'b0, 4'd2, 16'd0);
        do_single(1'b1, 1'b1, 4'd4, 16'h4444);
        do_single(1'b0, 1'b0, 4'd4, 16'd0);

        repeat (3) @(posedge Clock);
        #1;
        chk("sb_drained", sb.size(), 32'd0);
        chk("mem2_final", {16'd0, mem[2]}, {16'd0, shadow[2]});
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single-port 16x16 data memory between two requesters:
  - requester 0: processor load/store path;
  - requester 1: switch/debug loader.
- Sequences each access through a fixed 3-state FSM and arbitrates round-robin.
- Returns read data with a one-cycle ack pulse.
- Sits between the processor top level and the memory array, replacing direct addr/save wiring.

Parameters:
- DATA_W, 16, memory word width.
- ADDR_W, 4, memory address width (depth 2**ADDR_W).
- PROT_LIMIT, 4, addresses below this are write-protected from requester 1 (used only with the optional feature).

Ports:
- Clock  in  1  system clock, rising edge.
- Resetn  in  1  asynchronous active-low reset.
- req0  in  1  requester 0 access request.
- we0  in  1  requester 0 write enable (1 = store, 0 = load).
- addr0  in  ADDR_W  requester 0 address.
- wdata0  in  DATA_W  requester 0 write data.
- ack0  out  1  requester 0 completion pulse.
- rdata0  out  DATA_W  requester 0 read data, valid while ack0=1.
- req1, we1, addr1, wdata1, ack1, rdata1: as above, for requester 1.
- err1  out  1  requester 1 write rejected; valid with ack1 (optional feature only, else tied 0).
- mem_en  out  1  memory access strobe.
- mem_we  out  1  memory write enable.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  memory write data.
- mem_rdata  in  DATA_W  registered memory read data, valid the cycle after mem_en.

Behaviour:
- One clock domain (Clock). Resetn is asynchronous and active-low.
- Reset values:
  - state = IDLE, last_grant = 1, so requester 0 wins the first tie;
  - all outputs 0.
- FSM states: IDLE, ACCESS, RESP.
- IDLE:
  - No request pending: hold.
  - Exactly one req high: grant that requester.
  - Both high: grant the requester not equal to last_grant.
  - At the granting edge, register winner, mem_addr, mem_we, mem_wdata; set mem_en=1; update last_grant; go to ACCESS.
- ACCESS:
  - mem_en/mem_we are high for exactly this one cycle; memory samples at the closing edge.
  - Next edge: clear mem_en and mem_we; go to RESP.
- RESP:
  - ack of the winner is high for exactly this cycle; all other acks are 0.
  - rdata_winner = mem_rdata (for writes, rdata = 0).
  - Next edge: go to IDLE.
- Rdata registers hold their value after ack until the next RESP for that requester.
- Latency: req sampled high at edge N gives ack high in the cycle after edge N+2. Throughput is one access per 3 cycles.
- Handshake:
  - Requester holds req/we/addr/wdata stable until it sees ack.
  - Requester must drop req at the edge ending RESP.
  - A req still high in IDLE is a new access.
  - Request inputs are ignored outside IDLE; the loser keeps waiting and is granted next.
- Fairness: with both requests continuously asserted, grants alternate 0,1,0,1,… No requester waits more than one other access.
- Reset mid-access: the FSM returns to IDLE immediately. mem_en/mem_we drop asynchronously, so no partial write occurs after Resetn falls. The pending request is lost and no ack is issued.
- Address wrap: none. Addresses are ADDR_W bits, and every value is valid.

Optional Feature:
- Macro: MEM_ARB_WR_PROTECT_EN.
- Defined: a requester-1 write with addr1 < PROT_LIMIT:
  - still passes through ACCESS, but mem_en=0 and mem_we=0, so the memory is untouched;
  - in RESP, ack1=1 and err1=1.
  - Requester-0 writes and all reads are unaffected.
- Undefined: no protection logic; err1 is constant 0.

Decomposition:
- Package mem_arb_pkg:
  - state enum {IDLE, ACCESS, RESP};
  - DATA_W/ADDR_W defaults;
  - requester index constants REQ_CPU=0, REQ_DBG=1.
- Sub-module rr_pick2: combinational two-way round-robin pick.
  - Inputs: req0, req1, last_grant.
  - Outputs: grant_valid, grant_idx.
  - Instantiated once.

Test Plan:
- Reset during activity: assert Resetn=0 mid-ACCESS of a write to addr 7 -> mem_we drops immediately, state IDLE, no ack, mem[7] unchanged.
- Single read: req0=1, we0=0, addr0=3, mem[3]=0x0004 -> mem_en pulses 1 cycle with mem_addr=3; ack0 high 2 cycles later with rdata0=0x0004.
- Write then read: req1 write addr 9 data 0xBEEF, then req0 read addr 9 -> ack1 first, then ack0 with rdata0=0xBEEF.
- Contention: req0 and req1 both held for 4 accesses from reset -> grant order 0,1,0,1; each ack is a single-cycle pulse.
- Held request: req0 kept high after ack0 -> a second access starts from IDLE; req1 raised meanwhile is served next.
- With MEM_ARB_WR_PROTECT_EN, PROT_LIMIT=4: req1 write addr 2 data 0x1234 -> ack1=1 and err1=1, mem_en stays 0, and a later read of addr 2 returns the old value. Req0 write addr 2 succeeds with err1=0.
